// File: rtl/data_sram_resp.sv
// Data-SRAM responder: owns the data array, zero-fills it after reset and answers
// fixed-timing requests one cycle later. Optional perf counters under DSRAM_PERF_CNT_EN.
//
// state | meaning
// INIT  | clearing word[init_idx], requests ignored
// RUN   | servicing requests, write-first read-back
module data_sram_resp #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        init_done,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state;
  logic [AW-1:0] init_idx;
  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] word_idx;
  logic [31:0]   cur_word;
  logic [31:0]   merged_word;
  logic          accept;
  logic          is_write;
  logic          unused_addr_bits;

  assign word_idx         = data_sram_addr[AW+1:2];
  assign cur_word         = mem[word_idx];
  assign accept           = (state == RUN) && data_sram_en;
  assign is_write         = |data_sram_wen;
  assign unused_addr_bits = ^{data_sram_addr[31:AW+2], data_sram_addr[1:0]};

  // With wen all-zero the merge is just the stored word, so reads share this path.
  always_comb begin
    merged_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (data_sram_wen[i]) merged_word[8*i +: 8] = data_sram_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) mem[init_idx] <= 32'h0;
      else if (accept && is_write) mem[word_idx] <= merged_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= INIT;
      init_idx        <= '0;
      init_done       <= 1'b0;
      data_sram_rdata <= 32'h0;
    end else begin
      case (state)
        INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == AW'(DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          if (data_sram_en) data_sram_rdata <= merged_word;
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef DSRAM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt <= 32'h0;
      wr_cnt <= 32'h0;
    end else if (accept) begin
      if (is_write) wr_cnt <= wr_cnt + 32'h1;
      else          rd_cnt <= rd_cnt + 32'h1;
    end
  end
`else
  assign rd_cnt = 32'h0;
  assign wr_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: driver pushes model expectations per edge,
// monitor pops and compares after each rising edge.
module tb_data_sram_resp;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic        init_done;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  data_sram_resp #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .init_done(init_done),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          step;
    logic [31:0] rdata;
    logic        done;
    logic [31:0] rd;
    logic [31:0] wr;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_mem [DEPTH];
  int          cyc = 0;
  logic [31:0] m_rdata = 32'h0;
  logic [31:0] m_rd = 32'h0;
  logic [31:0] m_wr = 32'h0;
  int          step_no = 0;
  int          errors = 0;
  int          checks = 0;

  // Model: after reset the array is all zero once DEPTH non-reset edges have passed;
  // requests before that are dropped.
  task automatic step(input logic r, input logic e, input logic [3:0] w,
                      input logic [31:0] a, input logic [31:0] d);
    exp_t        it;
    int          ix;
    logic [31:0] v;
    @(negedge clk);
    reset = r; data_sram_en = e; data_sram_wen = w;
    data_sram_addr = a; data_sram_wdata = d;
    if (r) begin
      cyc = 0; m_rdata = 32'h0; m_rd = 32'h0; m_wr = 32'h0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    end else if (cyc < DEPTH) begin
      cyc++;
    end else if (e) begin
      ix = int'(a / 4) % DEPTH;
      v = m_mem[ix];
      for (int b = 0; b < 4; b++) if (w[b]) v[8*b +: 8] = d[8*b +: 8];
      m_mem[ix] = v;
      m_rdata = v;
      if (w == 4'h0) m_rd++; else m_wr++;
    end
    it.step = step_no;
    it.rdata = m_rdata;
    it.done = (cyc >= DEPTH);
`ifdef DSRAM_PERF_CNT_EN
    it.rd = m_rd; it.wr = m_wr;
`else
    it.rd = 32'h0; it.wr = 32'h0;
`endif
    q.push_back(it);
    step_no++;
  endtask

  task automatic check(input string name, input int s, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, s, got, want);
    end
  endtask

  initial begin
    exp_t it;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        it = q.pop_front();
        check("rdata", it.step, data_sram_rdata, it.rdata);
        check("init_done", it.step, {31'h0, init_done}, {31'h0, it.done});
        check("rd_cnt", it.step, rd_cnt, it.rd);
        check("wr_cnt", it.step, wr_cnt, it.wr);
      end
    end
  end

  task automatic init_with_noise();
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom);
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    init_with_noise();
    step(1'b0, 1'b1, 4'h0, 32'h14, 32'h0);
    step(1'b0, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
    step(1'b0, 1'b1, 4'h0, 32'h40, 32'h0);
    step(1'b0, 1'b1, 4'h0, 32'h44, 32'h0);
    step(1'b0, 1'b1, 4'h5, 32'h40, 32'h11223344);
    step(1'b0, 1'b1, 4'h0, 32'h40, 32'h0);
    step(1'b0, 1'b1, 4'h0, 32'h43, 32'h0);
    step(1'b0, 1'b1, 4'h0, 32'h40 + DEPTH * 4, 32'h0);
    repeat (3) step(1'b0, 1'b0, 4'hF, 32'h44, 32'hFFFFFFFF);
    step(1'b0, 1'b1, 4'hF, 32'h8, 32'h5A5A5A5A);
    step(1'b1, 1'b1, 4'hF, 32'h8, 32'h12345678);
    init_with_noise();
    step(1'b0, 1'b1, 4'h0, 32'h8, 32'h0);
    // counter scenario from a fresh reset
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    init_with_noise();
    for (int i = 0; i < 10; i++) begin
      if (i < 5)      step(1'b0, 1'b1, 4'h0, 32'(i * 4), 32'h0);
      else if (i < 8) step(1'b0, 1'b1, 4'h3, 32'(i * 4), $urandom);
      else            step(1'b0, 1'b0, 4'hF, 32'h0, $urandom);
    end
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
           $urandom, $urandom);
    end
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk);
    #2;
    check("queue_drained", step_no, 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Responder end of the CPU data-SRAM interface. It accepts the fixed-timing requests issued by the execute stage (`data_sram_en`, `data_sram_wen`, `data_sram_addr`, `data_sram_wdata`) and returns `data_sram_rdata` one cycle later, when the memory stage consumes it. It owns the data-memory array and zero-initialises it after every reset. `init_done` tells the pipeline top when requests are being serviced.

## Interface
- `DEPTH`, default 4096: number of 32-bit words; must be a power of two, ≥ 2.
- `AW`, default 12: word-address width; must equal log2(`DEPTH`).
- `clk`  input  1: single clock; all state updates on its rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `data_sram_en`  input  1: request strobe for this cycle.
- `data_sram_wen`  input  4: byte-lane write enables; bit i covers bits [8i+7:8i]. All-zero with `en`=1 is a read.
- `data_sram_addr`  input  32: byte address. The word index is `addr[AW+1:2]`; `addr[1:0]` and `addr[31:AW+2]` are ignored, so high addresses alias.
- `data_sram_wdata`  input  32: write data, lane-aligned.
- `data_sram_rdata`  output  32: registered response word.
- `init_done`  output  1: 1 once zero-initialisation has completed.
- `rd_cnt`  output  32: accepted-read count (see Configuration).
- `wr_cnt`  output  32: accepted-write count (see Configuration).

## Operation
- **State machine**: two states, INIT and RUN. Reset forces INIT with init index 0.
- **INIT**
  - Each cycle, writes 32'h0 to word[index], then index increments.
  - After the cycle that writes index `DEPTH`-1, the next state is RUN.
  - All requests are ignored in INIT: no array write, `rdata` not updated, counters not updated.
- **RUN, request accepted when `en`=1**
  - **Read** (`wen`=0): `rdata` ← word[idx].
  - **Write** (`wen`≠0): only the enabled byte lanes of word[idx] are updated. `rdata` ← the merged post-write word (write-first).
  - With `en`=0: no array access, and `rdata` holds its previous value.
  - A request with `en`=0 and `wen`≠0 is a no-op.
- **Back-to-back access to the same word**: the second access observes the first one's write. There are no stale-read hazards.
- **Reset values**
  - `data_sram_rdata` = 32'h0; `init_done` = 0; `rd_cnt` = `wr_cnt` = 0; state INIT; index 0.
  - Array contents are not reset directly; INIT clears them.
- **Reset asserted mid-INIT or mid-RUN**: initialisation restarts from index 0 on the next cycle. Partially written words are cleared again.

## Timing
- Request sampled at rising edge k. The response is visible on `data_sram_rdata` after edge k and stays stable until the next accepted request.
- Latency is exactly 1 cycle. There is no handshake and no backpressure; every RUN request completes.
- Cycle 0 is the first cycle with `reset`=0:
  - INIT occupies cycles 0 … `DEPTH`-1.
  - `init_done` rises after edge `DEPTH`-1, i.e. it is first 1 in cycle `DEPTH`.
  - The first serviced request is the one sampled at edge `DEPTH`.
- `init_done` is registered. It stays 1 until the next reset.

## Configuration
- Macro: `DSRAM_PERF_CNT_EN`.
- **Defined**
  - `rd_cnt` increments on each accepted RUN read.
  - `wr_cnt` increments on each accepted RUN write.
  - Both are 32-bit counters that wrap from 32'hFFFFFFFF to 0.
  - Both reset to 0 and do not count during INIT.
- **Undefined**: the counters are not built. `rd_cnt` and `wr_cnt` are present and tied to 32'h0.

## Test plan
- **Init sequencing**: `DEPTH`=16; reset 3 cycles, then release. Required: `init_done`=0 in cycles 0–15 and 1 from cycle 16. A read of any index at edge 16 returns 32'h0.
- **Full-word write then read**:
  - write `addr`=0x40, `wen`=4'hF, `wdata`=0xDEADBEEF → `rdata`=0xDEADBEEF the next cycle;
  - read 0x40 → 0xDEADBEEF;
  - read 0x44 → 0x0.
- **Byte-lane merge**: after the full-word write above, write 0x40 with `wen`=4'b0101, `wdata`=0x11223344 → `rdata`=0xDE22BE44. A following read returns the same value.
- **Aliasing and hold**:
  - read 0x40 with `addr[1:0]`=2'b11 → 0xDE22BE44;
  - `addr` = 0x40 + (`DEPTH`×4) aliases to the same word → 0xDE22BE44;
  - then 3 cycles with `en`=0 → `rdata` is unchanged.
- **Reset mid-run**:
  - write 0x8 = 0x5A5A5A5A, then pulse reset for 1 cycle;
  - required: `rdata`=0 and `init_done`=0 right after reset;
  - requests issued during INIT are ignored;
  - after re-init, reading 0x8 returns 0x0.
- **Counters (`DSRAM_PERF_CNT_EN`)**: 5 reads, 3 writes and 2 cycles with `en`=0, all in RUN → `rd_cnt`=5, `wr_cnt`=3. Requests issued during INIT are not counted. Without the macro, both counters read 0 throughout.
